// File: rtl/rv32i_types.sv
// Shared types for the reservation station slice: ALU op enum, regfile
// operand bundle, ROB entry view, flush bundle and the RS entry struct.
package rv32i_types;

    localparam int depth = 8;
    localparam int size = 8;
    localparam logic [31:0] mask = 32'd7;
    localparam int width = 32;

    localparam int tag_w = 4;
    localparam int rob_w = $clog2(size);
    localparam int idx_w = $clog2(depth);
    localparam int cnt_w = $clog2(depth) + 1;
    localparam logic [tag_w-1:0] tag_mask = mask[tag_w-1:0];

    typedef enum logic [2:0] {
        alu_add,
        alu_sub,
        alu_and,
        alu_or,
        alu_xor,
        alu_sll,
        alu_srl,
        alu_sra
    } alu_ops;

    typedef struct packed {
        logic             busy_r1;
        logic [width-1:0] r1;
        logic             busy_r2;
        logic [width-1:0] r2;
    } rs_t;

    typedef struct packed {
        logic             rdy;
        logic [width-1:0] data;
    } sal2_t;

    typedef struct packed {
        logic             valid;
        logic [tag_w-1:0] front_tag;
        logic [tag_w-1:0] rear_tag;
        logic [tag_w-1:0] flush_tag;
    } flush_t;

    typedef struct packed {
        logic             valid;
        alu_ops           op;
        logic [tag_w-1:0] tag;
        logic             busy1;
        logic [width-1:0] val1;
        logic [rob_w-1:0] q1;
        logic             busy2;
        logic [width-1:0] val2;
        logic [rob_w-1:0] q2;
    } rs_entry_t;

    // Distance of a tag from the ROB head, modulo the ROB size.
    function automatic logic [tag_w-1:0] rob_age(
        input logic [tag_w-1:0] t,
        input logic [tag_w-1:0] f
    );
        return (t - f) & tag_mask;
    endfunction

endpackage

// File: rtl/rs_age_select.sv
// Combinational oldest-ready picker: among ready entries, returns the one
// whose tag is closest to the ROB head. Ports: ready, tags, front_tag in;
// valid, index out.
module rs_age_select
    import rv32i_types::*;
(
    input  logic [depth-1:0] ready,
    input  logic [tag_w-1:0] tags [depth],
    input  logic [tag_w-1:0] front_tag,
    output logic             valid,
    output logic [idx_w-1:0] index
);

    logic [tag_w-1:0] best;

    always_comb begin
        valid = 1'b0;
        index = '0;
        best = '0;
        for (int i = 0; i < depth; i++) begin
            if (ready[i] && (!valid || rob_age(tags[i], front_tag) < best)) begin
                valid = 1'b1;
                index = idx_w'(i);
                best = rob_age(tags[i], front_tag);
            end
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Tag-based reservation station: holds ALU ops until operands arrive from
// the ROB, then dispatches the oldest ready one over valid/ready.
// Ports: clk, rst (async active-low); issue_* from decode/regfile;
// rdest ROB snoop; flush bundle; disp_* to the ALU; count of live entries.
// Build option RS_ISSUE_BYPASS_EN: capture already-ready ROB data at issue.
module reservation_station
    import rv32i_types::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  alu_ops           issue_op,
    input  rs_t              issue_ops,
    input  logic [tag_w-1:0] issue_tag,
    input  sal2_t            rdest [size],
    input  flush_t           flush,
    output logic             disp_valid,
    input  logic             disp_ready,
    output alu_ops           disp_op,
    output logic [width-1:0] disp_a,
    output logic [width-1:0] disp_b,
    output logic [tag_w-1:0] disp_tag,
    output logic [cnt_w-1:0] count
);

    rs_entry_t ent [depth];
    rs_entry_t ent_nxt [depth];
    rs_entry_t new_ent;

    logic [depth-1:0] rdy_vec;
    logic [tag_w-1:0] tags [depth];
    logic             sel_valid;
    logic [idx_w-1:0] sel_idx;
    logic [idx_w-1:0] free_idx;
    logic             issue_fire;
    logic             disp_fire;
    logic             no_squash;
    logic [tag_w-1:0] win_len;

    always_comb begin
        count = '0;
        free_idx = '0;
        for (int i = depth - 1; i >= 0; i--) begin
            count = count + cnt_w'(ent[i].valid);
            if (!ent[i].valid) free_idx = idx_w'(i);
        end
    end

    always_comb begin
        for (int i = 0; i < depth; i++) begin
            rdy_vec[i] = ent[i].valid && !ent[i].busy1 && !ent[i].busy2;
            tags[i] = ent[i].tag;
        end
    end

    rs_age_select u_sel (
        .ready     (rdy_vec),
        .tags      (tags),
        .front_tag (flush.front_tag),
        .valid     (sel_valid),
        .index     (sel_idx)
    );

    assign issue_ready = count < cnt_w'(depth);
    assign issue_fire = issue_valid && issue_ready && !flush.valid;
    assign disp_valid = sel_valid && !flush.valid;
    assign disp_fire = disp_valid && disp_ready;

    // Rear+1 == flush point means the flush lands past everything in flight.
    assign no_squash = ((flush.rear_tag + 1'b1) & tag_mask) == flush.flush_tag;
    assign win_len = rob_age(flush.flush_tag, flush.front_tag);

    always_comb begin
        disp_op = alu_add;
        disp_a = '0;
        disp_b = '0;
        disp_tag = '0;
        if (disp_valid) begin
            disp_op = ent[sel_idx].op;
            disp_a = ent[sel_idx].val1;
            disp_b = ent[sel_idx].val2;
            disp_tag = ent[sel_idx].tag;
        end
    end

    always_comb begin
        new_ent = '0;
        new_ent.valid = 1'b1;
        new_ent.op = issue_op;
        new_ent.tag = issue_tag;
        new_ent.busy1 = issue_ops.busy_r1;
        new_ent.val1 = issue_ops.r1;
        new_ent.q1 = issue_ops.r1[rob_w-1:0];
        new_ent.busy2 = issue_ops.busy_r2;
        new_ent.val2 = issue_ops.r2;
        new_ent.q2 = issue_ops.r2[rob_w-1:0];
`ifdef RS_ISSUE_BYPASS_EN
        if (new_ent.busy1 && rdest[new_ent.q1].rdy) begin
            new_ent.busy1 = 1'b0;
            new_ent.val1 = rdest[new_ent.q1].data;
        end
        if (new_ent.busy2 && rdest[new_ent.q2].rdy) begin
            new_ent.busy2 = 1'b0;
            new_ent.val2 = rdest[new_ent.q2].data;
        end
`endif
    end

    always_comb begin
        for (int i = 0; i < depth; i++) begin
            ent_nxt[i] = ent[i];
            if (ent[i].valid && ent[i].busy1 && rdest[ent[i].q1].rdy) begin
                ent_nxt[i].busy1 = 1'b0;
                ent_nxt[i].val1 = rdest[ent[i].q1].data;
            end
            if (ent[i].valid && ent[i].busy2 && rdest[ent[i].q2].rdy) begin
                ent_nxt[i].busy2 = 1'b0;
                ent_nxt[i].val2 = rdest[ent[i].q2].data;
            end
            // Survivors lie in the circular window [front_tag, flush_tag).
            if (flush.valid && !no_squash &&
                rob_age(ent[i].tag, flush.front_tag) >= win_len) begin
                ent_nxt[i].valid = 1'b0;
            end
        end
        if (disp_fire) ent_nxt[sel_idx].valid = 1'b0;
        if (issue_fire) ent_nxt[free_idx] = new_ent;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < depth; i++) ent[i] <= '0;
        end else begin
            for (int i = 0; i < depth; i++) ent[i] <= ent_nxt[i];
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station: directed scenarios plus a
// randomized run against a queue-based model of the station.
module tb_reservation_station;
    import rv32i_types::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             issue_valid;
    logic             issue_ready;
    alu_ops           issue_op;
    rs_t              issue_ops;
    logic [tag_w-1:0] issue_tag;
    sal2_t            rdest [size];
    flush_t           flush;
    logic             disp_valid;
    logic             disp_ready;
    alu_ops           disp_op;
    logic [width-1:0] disp_a;
    logic [width-1:0] disp_b;
    logic [tag_w-1:0] disp_tag;
    logic [cnt_w-1:0] count;

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    reservation_station dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_op    (issue_op),
        .issue_ops   (issue_ops),
        .issue_tag   (issue_tag),
        .rdest       (rdest),
        .flush       (flush),
        .disp_valid  (disp_valid),
        .disp_ready  (disp_ready),
        .disp_op     (disp_op),
        .disp_a      (disp_a),
        .disp_b      (disp_b),
        .disp_tag    (disp_tag),
        .count       (count)
    );

    typedef struct {
        alu_ops      op;
        int          tag;
        bit          b1;
        bit          b2;
        logic [31:0] v1;
        logic [31:0] v2;
        int          q1;
        int          q2;
    } m_ent_t;

    m_ent_t mq[$];

    // Oldest fully-ready instruction, by ROB distance from the head.
    function automatic int m_pick();
        int best = -1;
        int ba = 99;
        int a;
        foreach (mq[i]) begin
            if (!mq[i].b1 && !mq[i].b2) begin
                a = (mq[i].tag - int'(flush.front_tag)) & 7;
                if (a < ba) begin
                    ba = a;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    function automatic void model_step();
        int p;
        bit fire;
        bit iss;
        bit keep_all;
        int wl;
        m_ent_t n;
        p = m_pick();
        fire = !flush.valid && p >= 0 && disp_ready;
        iss = issue_valid && !flush.valid && mq.size() < depth;
        n.op = issue_op;
        n.tag = int'(issue_tag);
        n.b1 = issue_ops.busy_r1;
        n.v1 = issue_ops.r1;
        n.q1 = int'(issue_ops.r1) & 7;
        n.b2 = issue_ops.busy_r2;
        n.v2 = issue_ops.r2;
        n.q2 = int'(issue_ops.r2) & 7;
`ifdef RS_ISSUE_BYPASS_EN
        if (n.b1 && rdest[n.q1].rdy) begin
            n.b1 = 0;
            n.v1 = rdest[n.q1].data;
        end
        if (n.b2 && rdest[n.q2].rdy) begin
            n.b2 = 0;
            n.v2 = rdest[n.q2].data;
        end
`endif
        foreach (mq[i]) begin
            if (mq[i].b1 && rdest[mq[i].q1].rdy) begin
                mq[i].b1 = 0;
                mq[i].v1 = rdest[mq[i].q1].data;
            end
            if (mq[i].b2 && rdest[mq[i].q2].rdy) begin
                mq[i].b2 = 0;
                mq[i].v2 = rdest[mq[i].q2].data;
            end
        end
        if (fire) mq.delete(p);
        if (flush.valid) begin
            keep_all = ((int'(flush.rear_tag) + 1) & 7) == int'(flush.flush_tag);
            wl = (int'(flush.flush_tag) - int'(flush.front_tag)) & 7;
            if (!keep_all) begin
                for (int i = mq.size() - 1; i >= 0; i--) begin
                    if (((mq[i].tag - int'(flush.front_tag)) & 7) >= wl) mq.delete(i);
                end
            end
        end
        if (iss) mq.push_back(n);
    endfunction

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 0;
        issue_op = alu_add;
        issue_ops = '0;
        issue_tag = '0;
        flush = '0;
        disp_ready = 0;
        foreach (rdest[i]) rdest[i] = '0;
    endtask

    task automatic set_issue(input alu_ops op, input int tag, input bit b1,
                             input logic [31:0] r1, input bit b2,
                             input logic [31:0] r2);
        issue_valid = 1;
        issue_op = op;
        issue_tag = 4'(tag);
        issue_ops.busy_r1 = b1;
        issue_ops.r1 = r1;
        issue_ops.busy_r2 = b2;
        issue_ops.r2 = r2;
    endtask

    task automatic test_reset();
        #2;
        n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b want 1", issue_ready); end
        n_tests++; if (disp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dvalid: got %0b want 0", disp_valid); end
        n_tests++; if (disp_a !== 32'd0 || disp_b !== 32'd0) begin n_fail++; $display("FAIL reset_ab: got %0h/%0h want 0/0", disp_a, disp_b); end
        n_tests++; if (disp_tag !== 4'd0 || disp_op !== alu_add) begin n_fail++; $display("FAIL reset_tagop: got %0d/%0d want 0/0", disp_tag, disp_op); end
    endtask

    task automatic test_basic();
        idle();
        disp_ready = 1;
        set_issue(alu_add, 2, 0, 32'd5, 0, 32'd7);
        #2;
        n_tests++; if (disp_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pre: got %0b want 0", disp_valid); end
        cyc();
        issue_valid = 0;
        #2;
        n_tests++; if (disp_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %0b want 1", disp_valid); end
        n_tests++; if (disp_a !== 32'd5 || disp_b !== 32'd7) begin n_fail++; $display("FAIL basic_ab: got %0d/%0d want 5/7", disp_a, disp_b); end
        n_tests++; if (disp_tag !== 4'd2 || disp_op !== alu_add) begin n_fail++; $display("FAIL basic_tag: got %0d/%0d want 2/0", disp_tag, disp_op); end
        n_tests++; if (count !== 4'd1) begin n_fail++; $display("FAIL basic_cnt1: got %0d want 1", count); end
        cyc();
        #2;
        n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL basic_cnt0: got %0d want 0", count); end
    endtask

    task automatic test_wakeup();
        idle();
        disp_ready = 1;
        set_issue(alu_sub, 4, 1, 32'd3, 0, 32'd9);
        cyc();
        issue_valid = 0;
        #2;
        n_tests++; if (disp_valid !== 1'b0) begin n_fail++; $display("FAIL wake_wait: got %0b want 0", disp_valid); end
        cyc();
        rdest[3].rdy = 1;
        rdest[3].data = 32'h55;
        #2;
        n_tests++; if (disp_valid !== 1'b0) begin n_fail++; $display("FAIL wake_rdycyc: got %0b want 0", disp_valid); end
        cyc();
        rdest[3].rdy = 0;
        #2;
        n_tests++; if (disp_valid !== 1'b1) begin n_fail++; $display("FAIL wake_valid: got %0b want 1", disp_valid); end
        n_tests++; if (disp_a !== 32'h55 || disp_b !== 32'd9) begin n_fail++; $display("FAIL wake_ab: got %0h/%0h want 55/9", disp_a, disp_b); end
        n_tests++; if (disp_tag !== 4'd4 || disp_op !== alu_sub) begin n_fail++; $display("FAIL wake_tag: got %0d/%0d want 4/1", disp_tag, disp_op); end
        cyc();
        #2;
        n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL wake_cnt: got %0d want 0", count); end
    endtask

    task automatic test_full();
        int f;
        int perm[8];
        int j;
        int t;
        int tmp;
        alu_ops ops_by_tag[8];
        idle();
        f = $urandom_range(0, 7);
        flush.front_tag = 4'(f);
        for (int i = 0; i < 8; i++) perm[i] = i;
        for (int i = 7; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = perm[i];
            perm[i] = perm[j];
            perm[j] = tmp;
        end
        for (int k = 0; k < 8; k++) begin
            ops_by_tag[perm[k]] = alu_ops'($urandom_range(0, 7));
            set_issue(ops_by_tag[perm[k]], perm[k], 0, 32'(100 + perm[k]), 0, 32'(200 + perm[k]));
            cyc();
        end
        set_issue(alu_xor, 0, 0, 32'hdead, 0, 32'hbeef);
        #2;
        n_tests++; if (count !== 4'd8) begin n_fail++; $display("FAIL full_cnt: got %0d want 8", count); end
        n_tests++; if (issue_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %0b want 0", issue_ready); end
        cyc();
        issue_valid = 0;
        #2;
        n_tests++; if (count !== 4'd8) begin n_fail++; $display("FAIL full_ninth: got %0d want 8", count); end
        disp_ready = 1;
        for (int k = 0; k < 8; k++) begin
            t = (f + k) & 7;
            #2;
            n_tests++; if (disp_valid !== 1'b1 || disp_tag !== 4'(t)) begin n_fail++; $display("FAIL full_order%0d: got v%0b tag %0d want v1 tag %0d", k, disp_valid, disp_tag, t); end
            n_tests++; if (disp_a !== 32'(100 + t) || disp_op !== ops_by_tag[t]) begin n_fail++; $display("FAIL full_data%0d: got %0d/%0d want %0d/%0d", k, disp_a, disp_op, 100 + t, ops_by_tag[t]); end
            cyc();
        end
        #2;
        n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL full_drain: got %0d want 0", count); end
    endtask

    task automatic test_flush();
        int tl[4];
        idle();
        tl = '{6, 5, 3, 2};
        flush.front_tag = 4'd2;
        flush.rear_tag = 4'd6;
        flush.flush_tag = 4'd4;
        foreach (tl[k]) begin
            set_issue(alu_and, tl[k], 0, 32'(tl[k] * 3), 0, 32'd1);
            cyc();
        end
        issue_valid = 0;
        #2;
        n_tests++; if (disp_valid !== 1'b1 || disp_tag !== 4'd2) begin n_fail++; $display("FAIL flush_pre: got v%0b tag %0d want v1 tag 2", disp_valid, disp_tag); end
        flush.valid = 1;
        #1;
        n_tests++; if (disp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dvalid: got %0b want 0", disp_valid); end
        cyc();
        flush.valid = 0;
        #2;
        n_tests++; if (count !== 4'd2) begin n_fail++; $display("FAIL flush_cnt: got %0d want 2", count); end
        flush.flush_tag = 4'd7;
        flush.valid = 1;
        #1;
        n_tests++; if (disp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_nsq_dv: got %0b want 0", disp_valid); end
        cyc();
        flush.valid = 0;
        disp_ready = 1;
        #2;
        n_tests++; if (count !== 4'd2) begin n_fail++; $display("FAIL flush_nsq_cnt: got %0d want 2", count); end
        n_tests++; if (disp_tag !== 4'd2 || disp_a !== 32'd6) begin n_fail++; $display("FAIL flush_s1: got tag %0d a %0d want 2/6", disp_tag, disp_a); end
        cyc();
        #2;
        n_tests++; if (disp_valid !== 1'b1 || disp_tag !== 4'd3) begin n_fail++; $display("FAIL flush_s2: got v%0b tag %0d want v1 tag 3", disp_valid, disp_tag); end
        cyc();
        #2;
        n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL flush_end: got %0d want 0", count); end
    endtask

    task automatic test_bypass();
        idle();
        disp_ready = 1;
        set_issue(alu_or, 1, 0, 32'h11, 1, 32'd5);
        rdest[5].rdy = 1;
        rdest[5].data = 32'h1234;
        cyc();
        issue_valid = 0;
        #2;
`ifdef RS_ISSUE_BYPASS_EN
        n_tests++; if (disp_valid !== 1'b1 || disp_b !== 32'h1234) begin n_fail++; $display("FAIL byp_n1: got v%0b b %0h want v1 b 1234", disp_valid, disp_b); end
`else
        n_tests++; if (disp_valid !== 1'b0) begin n_fail++; $display("FAIL byp_n1: got %0b want 0", disp_valid); end
        cyc();
        #2;
        n_tests++; if (disp_valid !== 1'b1 || disp_b !== 32'h1234) begin n_fail++; $display("FAIL byp_n2: got v%0b b %0h want v1 b 1234", disp_valid, disp_b); end
`endif
        n_tests++; if (disp_a !== 32'h11 || disp_tag !== 4'd1) begin n_fail++; $display("FAIL byp_a: got %0h/%0d want 11/1", disp_a, disp_tag); end
        cyc();
        rdest[5].rdy = 0;
        #2;
        n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL byp_cnt: got %0d want 0", count); end
    endtask

    task automatic test_reset_mid();
        idle();
        for (int k = 0; k < 3; k++) begin
            set_issue(alu_add, k, 0, 32'(k), 0, 32'(k));
            cyc();
        end
        issue_valid = 0;
        #2;
        n_tests++; if (disp_valid !== 1'b1 || count !== 4'd3) begin n_fail++; $display("FAIL rmid_pre: got v%0b cnt %0d want v1 cnt 3", disp_valid, count); end
        rst = 0;
        #1;
        n_tests++; if (disp_valid !== 1'b0 || count !== 4'd0) begin n_fail++; $display("FAIL rmid_clr: got v%0b cnt %0d want v0 cnt 0", disp_valid, count); end
        n_tests++; if (issue_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %0b want 1", issue_ready); end
        mq.delete();
        @(posedge clk);
        #1;
        rst = 1;
        set_issue(alu_sll, 3, 0, 32'd8, 0, 32'd2);
        cyc();
        issue_valid = 0;
        #2;
        n_tests++; if (count !== 4'd1 || disp_tag !== 4'd3) begin n_fail++; $display("FAIL rmid_first: got cnt %0d tag %0d want 1/3", count, disp_tag); end
        disp_ready = 1;
        cyc();
    endtask

    task automatic test_random();
        int p;
        bit ev;
        bit used;
        int free_t[$];
        for (int c = 0; c < 400; c++) begin
            disp_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) flush.front_tag = 4'($urandom_range(0, 7));
            flush.valid = ($urandom_range(0, 19) == 0);
            flush.rear_tag = 4'($urandom_range(0, 7));
            flush.flush_tag = 4'($urandom_range(0, 7));
            foreach (rdest[i]) begin
                rdest[i].rdy = ($urandom_range(0, 3) == 0);
                rdest[i].data = $urandom;
            end
            free_t = {};
            for (int t = 0; t < 8; t++) begin
                used = 0;
                foreach (mq[i]) if (mq[i].tag == t) used = 1;
                if (!used) free_t.push_back(t);
            end
            issue_valid = 0;
            if (free_t.size() > 0 && $urandom_range(0, 9) < 7) begin
                set_issue(alu_ops'($urandom_range(0, 7)),
                          free_t[$urandom_range(0, free_t.size() - 1)],
                          1'($urandom_range(0, 1)), $urandom,
                          1'($urandom_range(0, 1)), $urandom);
                if (issue_ops.busy_r1) issue_ops.r1 = 32'($urandom_range(0, 7));
                if (issue_ops.busy_r2) issue_ops.r2 = 32'($urandom_range(0, 7));
            end
            #2;
            p = m_pick();
            ev = !flush.valid && p >= 0;
            n_tests++; if (count !== 4'(mq.size())) begin n_fail++; $display("FAIL rnd_cnt c%0d: got %0d want %0d", c, count, mq.size()); end
            n_tests++; if (issue_ready !== (mq.size() < depth)) begin n_fail++; $display("FAIL rnd_ready c%0d: got %0b", c, issue_ready); end
            n_tests++; if (disp_valid !== ev) begin n_fail++; $display("FAIL rnd_dvalid c%0d: got %0b want %0b", c, disp_valid, ev); end
            if (ev) begin
                n_tests++; if (disp_tag !== 4'(mq[p].tag) || disp_op !== mq[p].op) begin n_fail++; $display("FAIL rnd_tag c%0d: got %0d/%0d want %0d/%0d", c, disp_tag, disp_op, mq[p].tag, mq[p].op); end
                n_tests++; if (disp_a !== mq[p].v1 || disp_b !== mq[p].v2) begin n_fail++; $display("FAIL rnd_ab c%0d: got %0h/%0h want %0h/%0h", c, disp_a, disp_b, mq[p].v1, mq[p].v2); end
            end
            cyc();
        end
        idle();
        disp_ready = 1;
        foreach (rdest[i]) begin
            rdest[i].rdy = 1;
            rdest[i].data = 32'(i);
        end
        for (int k = 0; k < 12; k++) cyc();
        #2;
        n_tests++; if (count !== 4'd0 || disp_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_drain: got cnt %0d v%0b want 0/0", count, disp_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle();
        rst = 1;
        #1;
        rst = 0;
        test_reset();
        @(posedge clk);
        #1;
        rst = 1;
        test_basic();
        test_wakeup();
        test_full();
        test_flush();
        test_bypass();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
